// File: rtl/inst_fetcher_pkg.sv
// Shared definitions for the instruction fetcher: data width, opcodes, FSM encoding,
// queue entry layout and the jal target helper.
package inst_fetcher_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

  // pc + sign-extended J-type immediate (imm[20:1] << 1)
  function automatic logic [XLEN-1:0] jal_target(input logic [XLEN-1:0] pc,
                                                 input logic [XLEN-1:0] inst);
    logic [XLEN-1:0] imm;
    imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    return pc + imm;
  endfunction

endpackage

// File: rtl/inst_fetcher_if.sv
// Fetch-side bus: icache request/response, decoder handshake and redirect/flush inputs.
// master = the fetcher, slave = the icache/decoder/ROB environment.
interface inst_fetcher_if;
  import inst_fetcher_pkg::*;

  logic            ic_req_valid;
  logic [XLEN-1:0] ic_req_addr;
  logic            ic_resp_valid;
  logic [XLEN-1:0] ic_resp_inst;
  logic            dec_valid;
  logic [XLEN-1:0] dec_inst;
  logic [XLEN-1:0] dec_pc;
  logic            dec_accept;
  logic            dec_redirect;
  logic [XLEN-1:0] dec_redirect_addr;
  logic            rob_flush;
  logic [XLEN-1:0] rob_flush_addr;

  modport master (
    output ic_req_valid, ic_req_addr, dec_valid, dec_inst, dec_pc,
    input  ic_resp_valid, ic_resp_inst, dec_accept,
    input  dec_redirect, dec_redirect_addr, rob_flush, rob_flush_addr
  );

  modport slave (
    input  ic_req_valid, ic_req_addr, dec_valid, dec_inst, dec_pc,
    output ic_resp_valid, ic_resp_inst, dec_accept,
    output dec_redirect, dec_redirect_addr, rob_flush, rob_flush_addr
  );

endinterface

// File: rtl/inst_fetcher_fetch_queue.sv
// In-order circular queue of {pc, inst} pairs with synchronous clear and
// simultaneous push/pop. DEPTH must be a power of two so the pointers wrap naturally.
module fetch_queue
  import inst_fetcher_pkg::*;
#(
  parameter int  DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  fetch_entry_t     push_data,
  input  logic             pop,
  output fetch_entry_t     head_data,
  output logic [CNT_W-1:0] count
);

  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  fetch_entry_t     mem_q [DEPTH];
  fetch_entry_t     mem_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push_s;
  logic             do_pop_s;

  // Qualify push/pop: pop on empty and push on full are ignored.
  always_comb begin
    do_push_s = push && (count_q != CNT_FULL);
    do_pop_s  = pop && (count_q != {CNT_W{1'b0}});
  end

  // Next-state for storage, pointers and occupancy; clear dominates everything.
  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (clear) begin
      head_d  = {PTR_W{1'b0}};
      tail_d  = {PTR_W{1'b0}};
      count_d = {CNT_W{1'b0}};
    end else begin
      if (do_push_s) begin
        mem_d[tail_q] = push_data;
        tail_d        = tail_q + PTR_ONE;
      end else begin
        tail_d = tail_q;
      end
      if (do_pop_s) begin
        head_d = head_q + PTR_ONE;
      end else begin
        head_d = head_q;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Queue state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q   <= '{default: '0};
      head_q  <= {PTR_W{1'b0}};
      tail_q  <= {PTR_W{1'b0}};
      count_q <= {CNT_W{1'b0}};
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Head is read straight out of storage; zero while empty.
  always_comb begin
    if (count_q != {CNT_W{1'b0}}) begin
      head_data = mem_q[head_q];
    end else begin
      head_data = '0;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/inst_fetcher.sv
// Fetch PC owner: issues icache word requests, queues {pc, inst} for the decoder and
// applies redirects/flushes. Define JAL_PREDICT_EN to follow jal targets at fetch time.
module inst_fetcher
  import inst_fetcher_pkg::*;
#(
  parameter int              QUEUE_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC    = 32'h0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  inst_fetcher_if.master        bus
);

  localparam int               CNT_W    = $clog2(QUEUE_DEPTH) + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(QUEUE_DEPTH);

  fetch_state_t     state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic             run_q, run_d;
  logic             redirect_s;
  logic [XLEN-1:0]  target_s;
  logic [XLEN-1:0]  seq_pc_s;
  logic             req_s;
  logic             push_s;
  logic             pop_s;
  logic             clear_s;
  fetch_entry_t     push_data_s;
  fetch_entry_t     head_s;
  logic [CNT_W-1:0] count_s;

  // ROB flush outranks a decoder redirect; targets are halfword-aligned.
  always_comb begin
    redirect_s = bus.rob_flush || bus.dec_redirect;
    if (bus.rob_flush) begin
      target_s = {bus.rob_flush_addr[XLEN-1:1], 1'b0};
    end else begin
      target_s = {bus.dec_redirect_addr[XLEN-1:1], 1'b0};
    end
  end

  // PC to fetch after the instruction currently returning from the icache.
  always_comb begin
`ifdef JAL_PREDICT_EN
    if (bus.ic_resp_inst[6:0] == OPCODE_JAL) begin
      seq_pc_s = jal_target(pc_q, bus.ic_resp_inst);
    end else begin
      seq_pc_s = pc_q + 32'd4;
    end
`else
    seq_pc_s = pc_q + 32'd4;
`endif
  end

  // Fetch FSM: one outstanding request; DROP swallows the response of a redirected fetch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    run_d   = 1'b1;
    req_s   = 1'b0;
    push_s  = 1'b0;
    clear_s = 1'b0;
    if (rdy) begin
      case (state_q)
        ST_IDLE: begin
          if (redirect_s) begin
            clear_s = 1'b1;
            pc_d    = target_s;
          end else if (run_q && (count_s < CNT_FULL)) begin
            req_s   = 1'b1;
            state_d = ST_WAIT;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (redirect_s) begin
            clear_s = 1'b1;
            pc_d    = target_s;
            state_d = bus.ic_resp_valid ? ST_IDLE : ST_DROP;
          end else if (bus.ic_resp_valid) begin
            push_s  = 1'b1;
            pc_d    = seq_pc_s;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_WAIT;
          end
        end
        ST_DROP: begin
          if (redirect_s) begin
            clear_s = 1'b1;
            pc_d    = target_s;
          end else begin
            pc_d = pc_q;
          end
          if (bus.ic_resp_valid) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DROP;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else begin
      run_d = run_q;
    end
  end

  // FSM, PC and the post-reset issue enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      run_q   <= run_d;
    end
  end

  // Decoder pop; a same-cycle redirect still clears the queue, the clear wins.
  always_comb begin
    pop_s       = rdy && bus.dec_accept;
    push_data_s = '{pc: pc_q, inst: bus.ic_resp_inst};
  end

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear_s),
    .push      (push_s),
    .push_data (push_data_s),
    .pop       (pop_s),
    .head_data (head_s),
    .count     (count_s)
  );

  assign bus.ic_req_valid = req_s;
  assign bus.ic_req_addr  = req_s ? pc_q : {XLEN{1'b0}};
  assign bus.dec_valid    = (count_s != {CNT_W{1'b0}});
  assign bus.dec_inst     = head_s.inst;
  assign bus.dec_pc       = head_s.pc;

endmodule

// File: tb/tb_inst_fetcher.sv
// Directed bench for inst_fetcher: reset, fill/backpressure, redirects, flush priority,
// redirect/response collision, jal prediction (both builds) and rdy freeze.
module tb_inst_fetcher;

  logic clk;
  logic rst;
  logic rdy;

  inst_fetcher_if bus_if ();

  inst_fetcher #(
    .QUEUE_DEPTH (4),
    .RESET_PC    (32'h0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (bus_if)
  );

`ifdef JAL_PREDICT_EN
  localparam logic [31:0] JAL_NEXT = 32'h18;
`else
  localparam logic [31:0] JAL_NEXT = 32'h14;
`endif

  int          total_cnt;
  int          bad_cnt;
  logic [31:0] req_log [$];
  bit          ic_auto;
  bit          auto_pend;
  logic [31:0] auto_addr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout total=%0d bad=%0d", total_cnt, bad_cnt);
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] inst_of(input logic [31:0] addr);
    return {addr[23:0], 8'h13};
  endfunction

  // Advance one cycle: log any request seen mid-cycle, land at posedge+2 for driving.
  task automatic tick();
    @(negedge clk);
    if (bus_if.ic_req_valid === 1'b1) begin
      req_log.push_back(bus_if.ic_req_addr);
      if (ic_auto) begin
        auto_pend = 1'b1;
        auto_addr = bus_if.ic_req_addr;
      end
    end
    @(posedge clk);
    #2;
    if (ic_auto) begin
      bus_if.ic_resp_valid = auto_pend;
      bus_if.ic_resp_inst  = auto_pend ? inst_of(auto_addr) : 32'h0;
      auto_pend = 1'b0;
    end
  endtask

  initial begin
    total_cnt = 0;
    bad_cnt   = 0;
    ic_auto   = 1'b0;
    auto_pend = 1'b0;
    auto_addr = 32'h0;
    rst = 1'b1;
    rdy = 1'b1;
    bus_if.ic_resp_valid     = 1'b0;
    bus_if.ic_resp_inst      = 32'h0;
    bus_if.dec_accept        = 1'b0;
    bus_if.dec_redirect      = 1'b0;
    bus_if.dec_redirect_addr = 32'h0;
    bus_if.rob_flush         = 1'b0;
    bus_if.rob_flush_addr    = 32'h0;

    // reset state
    repeat (2) @(posedge clk);
    #3;
    check_eq("rst_req_valid", {31'h0, bus_if.ic_req_valid}, 32'h0);
    check_eq("rst_req_addr",  bus_if.ic_req_addr, 32'h0);
    check_eq("rst_dec_valid", {31'h0, bus_if.dec_valid}, 32'h0);
    check_eq("rst_dec_pc",    bus_if.dec_pc, 32'h0);
    check_eq("rst_dec_inst",  bus_if.dec_inst, 32'h0);
    rst = 1'b0;

    // latency-1 icache, decoder never accepts
    ic_auto = 1'b1;
    tick();
    #1;
    check_eq("first_req_valid", {31'h0, bus_if.ic_req_valid}, 32'h1);
    check_eq("first_req_addr",  bus_if.ic_req_addr, 32'h0);
    tick();
    #1;
    check_eq("dec_valid_early", {31'h0, bus_if.dec_valid}, 32'h0);
    tick();
    #1;
    check_eq("dec_valid_2cyc", {31'h0, bus_if.dec_valid}, 32'h1);
    check_eq("dec_pc_first",   bus_if.dec_pc, 32'h0);
    check_eq("dec_inst_first", bus_if.dec_inst, inst_of(32'h0));
    for (int i = 0; i < 16; i++) tick();
    check_eq("fill_req_count", 32'(req_log.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("fill_req_addr%0d", i), req_log[i], 32'(4 * i));
    end
    check_eq("full_head_pc", bus_if.dec_pc, 32'h0);

    // full queue, one accept -> exactly one refill request
    req_log.delete();
    bus_if.dec_accept = 1'b1;
    tick();
    bus_if.dec_accept = 1'b0;
    #1;
    check_eq("refill_req_valid", {31'h0, bus_if.ic_req_valid}, 32'h1);
    check_eq("refill_req_addr",  bus_if.ic_req_addr, 32'h10);
    check_eq("refill_head_pc",   bus_if.dec_pc, 32'h4);
    for (int i = 0; i < 8; i++) tick();
    check_eq("refill_req_count", 32'(req_log.size()), 32'd1);
    check_eq("refill_log_addr",  req_log[0], 32'h10);
    check_eq("refill_head_hold", bus_if.dec_pc, 32'h4);

    // redirect while WAIT, response arrives later and is dropped
    ic_auto = 1'b0;
    bus_if.dec_accept = 1'b1;
    tick();
    bus_if.dec_accept = 1'b0;
    #1;
    check_eq("pre_redir_req", bus_if.ic_req_addr, 32'h14);
    tick();
    bus_if.dec_redirect      = 1'b1;
    bus_if.dec_redirect_addr = 32'h100;
    tick();
    bus_if.dec_redirect = 1'b0;
    #1;
    check_eq("drop_dec_valid", {31'h0, bus_if.dec_valid}, 32'h0);
    check_eq("drop_no_req",    {31'h0, bus_if.ic_req_valid}, 32'h0);
    tick();
    bus_if.ic_resp_valid = 1'b1;
    bus_if.ic_resp_inst  = 32'hdeadbeef;
    #1;
    check_eq("drop_resp_no_req", {31'h0, bus_if.ic_req_valid}, 32'h0);
    tick();
    bus_if.ic_resp_valid = 1'b0;
    #1;
    check_eq("after_drop_dec_valid", {31'h0, bus_if.dec_valid}, 32'h0);
    check_eq("after_drop_req_valid", {31'h0, bus_if.ic_req_valid}, 32'h1);
    check_eq("after_drop_req_addr",  bus_if.ic_req_addr, 32'h100);

    // flush and redirect together: flush wins, bit0 cleared
    bus_if.rob_flush         = 1'b1;
    bus_if.rob_flush_addr    = 32'h201;
    bus_if.dec_redirect      = 1'b1;
    bus_if.dec_redirect_addr = 32'h300;
    #1;
    check_eq("redir_idle_no_req", {31'h0, bus_if.ic_req_valid}, 32'h0);
    tick();
    bus_if.rob_flush    = 1'b0;
    bus_if.dec_redirect = 1'b0;
    #1;
    check_eq("flush_prio_addr", bus_if.ic_req_addr, 32'h200);

    // redirect coincident with response
    tick();
    bus_if.ic_resp_valid     = 1'b1;
    bus_if.ic_resp_inst      = 32'h12345013;
    bus_if.dec_redirect      = 1'b1;
    bus_if.dec_redirect_addr = 32'h400;
    tick();
    bus_if.ic_resp_valid = 1'b0;
    bus_if.dec_redirect  = 1'b0;
    #1;
    check_eq("coinc_dec_valid", {31'h0, bus_if.dec_valid}, 32'h0);
    check_eq("coinc_req_valid", {31'h0, bus_if.ic_req_valid}, 32'h1);
    check_eq("coinc_req_addr",  bus_if.ic_req_addr, 32'h400);

    // jal at pc 0x10
    bus_if.dec_redirect      = 1'b1;
    bus_if.dec_redirect_addr = 32'h10;
    tick();
    bus_if.dec_redirect = 1'b0;
    #1;
    check_eq("jal_req_addr", bus_if.ic_req_addr, 32'h10);
    tick();
    bus_if.ic_resp_valid = 1'b1;
    bus_if.ic_resp_inst  = 32'h0080006f;
    tick();
    bus_if.ic_resp_valid = 1'b0;
    #1;
    check_eq("jal_dec_pc",   bus_if.dec_pc, 32'h10);
    check_eq("jal_dec_inst", bus_if.dec_inst, 32'h0080006f);
    check_eq("jal_next_req", bus_if.ic_req_addr, JAL_NEXT);

    // rdy low freezes everything
    rdy = 1'b0;
    #1;
    check_eq("rdy_low_no_req", {31'h0, bus_if.ic_req_valid}, 32'h0);
    tick();
    #1;
    check_eq("rdy_low_hold_pc", bus_if.dec_pc, 32'h10);
    rdy = 1'b1;
    #1;
    check_eq("rdy_high_req", bus_if.ic_req_addr, JAL_NEXT);

    // push and pop in the same cycle keep one entry
    tick();
    bus_if.ic_resp_valid = 1'b1;
    bus_if.ic_resp_inst  = 32'h00000013;
    bus_if.dec_accept    = 1'b1;
    tick();
    bus_if.ic_resp_valid = 1'b0;
    bus_if.dec_accept    = 1'b0;
    #1;
    check_eq("pushpop_valid", {31'h0, bus_if.dec_valid}, 32'h1);
    check_eq("pushpop_pc",    bus_if.dec_pc, JAL_NEXT);
    check_eq("pushpop_inst",  bus_if.dec_inst, 32'h00000013);
    check_eq("pushpop_req",   bus_if.ic_req_addr, JAL_NEXT + 32'h4);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule

// File: doc/inst_fetcher.md
Name: inst_fetcher

Overview:
Producer end of the decoder's fetch interface. Owns the fetch PC, issues word requests to the instruction cache and buffers returned {pc, inst} pairs in a small in-order queue. Presents the queue head to the decoder with a valid/accept handshake. Applies redirects from the decoder (jal/jalr/branch) and flushes from the reorder buffer, discarding stale in-flight responses.

Parameters:
QUEUE_DEPTH, 4, instruction queue entries (power of 2, >=2)
RESET_PC, 32'h0, fetch PC after reset

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
rdy  in  1  global enable; when low all state holds, no new ic request
ic_req_valid  out  1  one-cycle request pulse to icache
ic_req_addr  out  32  word address of request, valid with ic_req_valid
ic_resp_valid  in  1  one-cycle response pulse, >=1 cycle after request
ic_resp_inst  in  32  instruction word with ic_resp_valid
dec_valid  out  1  queue head valid (decoder's instcache_ready_out)
dec_inst  out  32  queue head instruction
dec_pc  out  32  queue head PC
dec_accept  in  1  decoder consumes head this cycle (only honoured when dec_valid)
dec_redirect  in  1  decoder redirect (clear_inst)
dec_redirect_addr  in  32  redirect target (if_addr)
rob_flush  in  1  mispredict/exception flush
rob_flush_addr  in  32  flush target

Behaviour:
- Reset: fetch_pc=RESET_PC, queue empty (head=tail=count=0), state IDLE, ic_req_valid=0, ic_req_addr=0, dec_valid=0; dec_inst/dec_pc=0 while empty.
- Redirect priority: rob_flush over dec_redirect; target = chosen addr with bit0 cleared.
- FSM states IDLE, WAIT, DROP.
- IDLE: if no redirect and count + (push this cycle) < QUEUE_DEPTH: pulse ic_req_valid, ic_req_addr=fetch_pc, go WAIT. Otherwise stay.
- WAIT: on ic_resp_valid (no redirect): push {fetch_pc, ic_resp_inst}, fetch_pc+=4, go IDLE. Next request no earlier than the following cycle; steady-state throughput = one instruction per (icache latency + 1) cycles.
- Redirect in IDLE: queue cleared, fetch_pc=target, stay IDLE; request may issue next cycle.
- Redirect in WAIT without resp: queue cleared, fetch_pc=target, go DROP.
- Redirect in WAIT coinciding with ic_resp_valid: response discarded, queue cleared, fetch_pc=target, go IDLE.
- DROP: no request; on ic_resp_valid discard, go IDLE. A further redirect in DROP updates fetch_pc and stays DROP (or goes IDLE if resp arrives same cycle).
- A redirect clears the queue even if dec_accept is asserted the same cycle; the accepted head is still considered consumed by the decoder.
- Queue: circular, pointers wrap modulo QUEUE_DEPTH; push and pop in the same cycle allowed, count unchanged. Push never occurs when full (guaranteed by issue rule). dec_accept when empty ignored.
- dec_valid = count!=0 and no redirect pending is NOT required; outputs are registered queue head, combinational from storage.
- rdy low: freeze FSM, PC, queue; ic_resp_valid while rdy low is not permitted by icache contract.

Optional Feature:
JAL_PREDICT_EN: when defined, on pushing an instruction whose opcode==7'b1101111, fetch_pc becomes pc + sign-extended immJ (imm[20:1]<<1) instead of pc+4. Without it, always pc+4 and the decoder's jal redirect corrects the stream. Redirect handling unchanged in both builds.

Decomposition:
- Shared package/const header: opcode localparams (OPCODE_JAL etc.), FSM state encoding, XLEN=32.
- Sub-module fetch_queue (parameterised circular FIFO with clear, simultaneous push/pop, count output); FSM and PC logic stay in inst_fetcher.

Test Plan:
- Reset, icache latency 1 -> requests to 0x0,0x4,0x8; dec_valid with dec_pc=0x0 two cycles after first request; queue holds 4 entries when decoder never accepts, no 5th request.
- Full queue, dec_accept one cycle -> exactly one new request at next sequential PC, count returns to 4.
- dec_redirect to 0x100 while WAIT, resp 2 cycles later -> response dropped, dec_valid low, next request addr 0x100.
- rob_flush 0x200 and dec_redirect 0x300 same cycle -> fetch resumes at 0x200.
- Redirect coincident with ic_resp_valid -> resp not enqueued, next cycle request at target.
- JAL_PREDICT_EN, inst 0x0080006f at pc 0x10 -> next request 0x18; without macro -> 0x14.
